iurt_dwn_decoder: RTL and testbench

IURT_DWN_DECODER -- requirements
Module: iurt_dwn_decoder

---
 rtl/iurt_pkg.sv | 11 +
 rtl/iurt_byte_fifo.sv | 64 ++++++
 rtl/iurt_dwn_decoder.sv | 82 ++++++++
 tb/tb_iurt_dwn_decoder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/iurt_pkg.sv
// Shared IURT definitions: escape/reset symbol defaults and the downstream
// decoder FSM state encoding.
package iurt_pkg;
  localparam logic [7:0] IURT_ESC_SYM = 8'h55;
  localparam logic [7:0] IURT_RST_SYM = 8'hEE;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_ESCAPED = 1'b1
  } dwn_state_e;
endpackage

// File: rtl/iurt_byte_fifo.sv
// Show-ahead byte FIFO with clock enable, synchronous flush and a sticky
// overflow flag for bytes dropped while full.
module iurt_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ce,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_ready,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic [7:0]               o_data,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_full, w_empty, w_pop, w_push, w_drop;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_ce & ~w_empty & i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = i_ce & i_push & (~w_full | w_pop);
  assign w_drop  = i_ce & i_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_ce) begin
      if (i_flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
        else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
        if (w_drop) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_rd == r_rd ? r_wr : r_wr] <= i_data;
  end

  // RAM is not reset, so the head is masked while empty.
  assign o_valid    = ~w_empty;
  assign o_data     = w_empty ? 8'h00 : r_mem[r_rd];
  assign o_overflow = r_ovf;
  assign o_count    = r_count;
endmodule

// File: rtl/iurt_dwn_decoder.sv
// Downstream hub-to-controller decoder: strips ESC escapes, turns ESC,RST
// into a reset_req pulse plus FIFO flush, and buffers bytes in a FIFO.
module iurt_dwn_decoder
  import iurt_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [7:0] ESC_SYM = IURT_ESC_SYM,
  parameter logic [7:0] RST_SYM = IURT_RST_SYM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   hub_valid,
  input  logic [7:0]             hub_data,
  input  logic                   data_dwn_ready,
  output logic                   data_dwn_valid,
  output logic [7:0]             data_dwn,
  output logic                   reset_req,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill_level
);
  dwn_state_e r_state, w_next;
  logic       w_accept, w_is_esc, w_is_rst;
  logic       w_push, w_flush, w_rreq;

  assign w_accept = ce & hub_valid;
  assign w_is_esc = (hub_data == ESC_SYM);
  assign w_is_rst = (hub_data == RST_SYM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_state <= ST_IDLE;
    else if (ce) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE:    w_next = w_is_esc ? ST_ESCAPED : ST_IDLE;
        ST_ESCAPED: w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // In ESCAPED every byte except RST_SYM is pushed as-is, including ESC_SYM.
  always_comb begin
    w_push  = 1'b0;
    w_flush = 1'b0;
    w_rreq  = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: w_push = ~w_is_esc;
        ST_ESCAPED: begin
          if (w_is_rst) begin
            w_flush = 1'b1;
            w_rreq  = 1'b1;
          end else begin
            w_push  = 1'b1;
          end
        end
        default: w_push = 1'b0;
      endcase
    end
  end

  assign reset_req = w_rreq;

  iurt_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_ce       (ce),
    .i_push     (w_push),
    .i_data     (hub_data),
    .i_ready    (data_dwn_ready),
    .i_flush    (w_flush),
    .o_valid    (data_dwn_valid),
    .o_data     (data_dwn),
    .o_overflow (overflow),
    .o_count    (fill_level)
  );
endmodule

// File: tb/tb_iurt_dwn_decoder.sv
// Scoreboard bench for iurt_dwn_decoder: directed hub byte streams, expected
// output bytes queued at stimulus time and checked by a pop monitor.
module tb_iurt_dwn_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       hub_valid = 1'b0;
  logic [7:0] hub_data = 8'h00;
  logic       data_dwn_ready = 1'b0;
  logic       data_dwn_valid;
  logic [7:0] data_dwn;
  logic       reset_req;
  logic       overflow;
  logic [4:0] fill_level;

  int n_pass = 0;
  int n_total = 0;
  int rr_count = 0;
  int rr0;
  logic [7:0] exp_q[$];

  iurt_dwn_decoder #(.DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .hub_valid      (hub_valid),
    .hub_data       (hub_data),
    .data_dwn_ready (data_dwn_ready),
    .data_dwn_valid (data_dwn_valid),
    .data_dwn       (data_dwn),
    .reset_req      (reset_req),
    .overflow       (overflow),
    .fill_level     (fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    hub_valid = 1'b1;
    hub_data  = b;
    tick();
    hub_valid = 1'b0;
  endtask

  // Pops happen at the next rising edge; compare the head against the queue.
  always @(negedge clk) begin
    if (!rst && ce && data_dwn_valid && data_dwn_ready) begin
      chk("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("pop_data", data_dwn, exp_q.pop_front());
    end
    if (!rst && ce && reset_req) rr_count++;
  end

  initial begin
    #3;
    chk("rst_valid", data_dwn_valid, 0);
    chk("rst_data", data_dwn, 8'h00);
    chk("rst_reset_req", reset_req, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fill", fill_level, 0);
    tick(); tick();
    rst = 1'b0;
    data_dwn_ready = 1'b1;

    // Plain bytes, one-cycle push-to-visible latency, no bypass.
    exp_q.push_back(8'h42);
    hub_valid = 1'b1; hub_data = 8'h42;
    #1 chk("no_bypass_valid", data_dwn_valid, 0);
    tick();
    chk("lat_data_42", data_dwn, 8'h42);
    chk("lat_valid_42", data_dwn_valid, 1);
    exp_q.push_back(8'h13);
    hub_data = 8'h13;
    tick();
    hub_valid = 1'b0;
    chk("lat_data_13", data_dwn, 8'h13);
    tick(); tick();

    // ESC ESC -> literal ESC; ESC RST -> reset pulse and flush.
    rr0 = rr_count;
    send(8'h55);
    exp_q.push_back(8'h55);
    send(8'h55);
    send(8'h55);
    send(8'hEE);
    tick();
    chk("esc_rr_pulses", rr_count - rr0, 1);
    chk("esc_fill", fill_level, 0);
    chk("esc_queue_drained", exp_q.size(), 0);

    // Fill to full, then push-with-pop, then drop.
    data_dwn_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i));
    end
    chk("full_fill", fill_level, 16);
    chk("full_overflow", overflow, 0);
    chk("full_head_stable", data_dwn, 8'h00);
    data_dwn_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send(8'hA5);
    data_dwn_ready = 1'b0;
    chk("fullpop_fill", fill_level, 16);
    chk("fullpop_overflow", overflow, 0);
    send(8'h10);
    chk("drop_fill", fill_level, 16);
    chk("drop_overflow", overflow, 1);
    data_dwn_ready = 1'b1;
    for (int k = 0; k < 40 && fill_level != 0; k++) tick();
    chk("drain_fill", fill_level, 0);
    chk("drain_queue", exp_q.size(), 0);
    rr0 = rr_count;
    send(8'h55);
    send(8'hEE);
    chk("ovf_cleared", overflow, 0);
    chk("ovf_rr_pulses", rr_count - rr0, 1);

    // ce=0 freezes the FSM in ESCAPED and ignores hub bytes.
    send(8'h55);
    ce = 1'b0;
    hub_valid = 1'b1; hub_data = 8'h77;
    tick(); tick(); tick();
    hub_valid = 1'b0;
    chk("ce0_fill", fill_level, 0);
    chk("ce0_valid", data_dwn_valid, 0);
    ce = 1'b1;
    exp_q.push_back(8'h55);
    send(8'h55);
    chk("ce0_state_held", fill_level, 1);
    tick(); tick();

    // Async reset mid-escape discards FIFO contents and the pending escape.
    data_dwn_ready = 1'b0;
    send(8'h11);
    send(8'h55);
    chk("pre_rst_fill", fill_level, 1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_fill", fill_level, 0);
    chk("async_rst_valid", data_dwn_valid, 0);
    chk("async_rst_data", data_dwn, 8'h00);
    tick();
    rst = 1'b0;
    rr0 = rr_count;
    data_dwn_ready = 1'b1;
    exp_q.push_back(8'hEE);
    send(8'hEE);
    chk("post_rst_data", data_dwn, 8'hEE);
    tick(); tick();
    chk("post_rst_no_rr", rr_count - rr0, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
